// File: rtl/led_share_arbiter_if.sv
// rtl/led_share_arbiter_if.sv - request/grant/LED bundle between requesters and the LED share arbiter
//
// Purpose: groups the requester-facing and LED-facing signals of led_share_arbiter.
// Signals:
//   req_i         requester -> arbiter, one request bit per requester
//   data_i        requester -> arbiter, requester k pattern at [k*LED_W +: LED_W]
//   grant_o       arbiter -> requesters, one-hot current owner or zero
//   owner_valid_o arbiter -> requesters, high while a grant is active
//   owner_o       arbiter -> requesters, index of current (or last) owner
//   led_o         arbiter -> LED pins, registered LED drive
// Modports: master (requester side / bench), slave (arbiter side).

interface led_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int LED_W = 10
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*LED_W-1:0] data_i;
  logic [N_REQ-1:0]       grant_o;
  logic                   owner_valid_o;
  logic [OW-1:0]          owner_o;
  logic [LED_W-1:0]       led_o;

  modport master (
    output req_i, data_i,
    input  grant_o, owner_valid_o, owner_o, led_o
  );

  modport slave (
    input  req_i, data_i,
    output grant_o, owner_valid_o, owner_o, led_o
  );
endinterface

// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - round-robin owner arbiter for the shared board LED bank
//
// Purpose: grants the LED bank to one requester at a time (round-robin from the
// requester after the last owner), preempts an owner after MAX_HOLD cycles only
// when someone else is waiting, and drives a registered LED output.
// Optional feature macro: LED_GUARD_EN - every release passes through a
// GUARD_CYCLES blank interval before the next arbitration.
// Ports:
//   clk_clk        in  sole clock
//   reset_reset_n  in  asynchronous active-low reset
//   bus            slave modport of led_share_arbiter_if (req_i, data_i in;
//                  grant_o, owner_valid_o, owner_o, led_o out)

module led_share_arbiter #(
  parameter int LED_W    = 10,
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 4096
`ifdef LED_GUARD_EN
  , parameter int GUARD_CYCLES = 16
`endif
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  led_share_arbiter_if.slave bus
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

`ifdef LED_GUARD_EN
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, OWN, GUARD} state_t;
`else
  typedef enum logic [0:0] {IDLE, OWN} state_t;
`endif

  state_t           state_q;
  logic [N_REQ-1:0] grant_q;
  logic             valid_q;
  logic [OW-1:0]    owner_q;
  logic [LED_W-1:0] led_q;
  logic [OW-1:0]    rr_ptr;
  logic [HW-1:0]    hold_cnt;
`ifdef LED_GUARD_EN
  logic [GW-1:0]    guard_cnt;
`endif

  logic [OW-1:0]    next_owner;
  logic [OW-1:0]    scan_ptr;
  logic [OW-1:0]    win_idx;
  logic             win_found;
  logic             release_now;
  logic [LED_W-1:0] led_sel;

  assign next_owner = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // While owning, the next winner is searched from the requester after the
  // current owner; when idle (or leaving guard) rr_ptr already holds that value.
  assign scan_ptr = (state_q == OWN) ? next_owner : rr_ptr;

  always_comb begin : arbitrate
    logic [OW-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = OW'((int'(scan_ptr) + i) % N_REQ);
      if (!win_found && bus.req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Voluntary drop, or quantum used up while someone else waits. A lone owner
  // lets hold_cnt saturate, so ">=" makes a late arrival preempt at once.
  assign release_now = !bus.req_i[owner_q] ||
                       ((hold_cnt >= HW'(MAX_HOLD - 1)) && |(bus.req_i & ~grant_q));

  always_comb begin
    led_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) led_sel = bus.data_i[k*LED_W +: LED_W];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      owner_q   <= '0;
      led_q     <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
`ifdef LED_GUARD_EN
      guard_cnt <= '0;
`endif
    end else begin
      led_q <= valid_q ? led_sel : '0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            grant_q  <= ONE << win_idx;
            owner_q  <= win_idx;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
            state_q  <= OWN;
          end
        end
        OWN: begin
          if (hold_cnt != HW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
          if (release_now) begin
            rr_ptr <= next_owner;
`ifdef LED_GUARD_EN
            grant_q   <= '0;
            valid_q   <= 1'b0;
            guard_cnt <= '0;
            state_q   <= GUARD;
`else
            if (win_found) begin
              grant_q  <= ONE << win_idx;
              owner_q  <= win_idx;
              hold_cnt <= '0;
            end else begin
              grant_q <= '0;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
`endif
          end
        end
`ifdef LED_GUARD_EN
        GUARD: begin
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
            if (win_found) begin
              grant_q  <= ONE << win_idx;
              owner_q  <= win_idx;
              valid_q  <= 1'b1;
              hold_cnt <= '0;
              state_q  <= OWN;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_o       = grant_q;
  assign bus.owner_valid_o = valid_q;
  assign bus.owner_o       = owner_q;
  assign bus.led_o         = led_q;

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Round-robin arbiter that shares the 10-bit board LED bank between up to N_REQ requesters, for example the HPS LED PIO export, a switch-mirror path and an FPGA heartbeat.
- Each requester presents a request and an LED pattern.
- The block grants one owner at a time, enforces a time quantum when others are waiting, and drives the registered LED output.
- Sits in the top-level fabric between the soc_system PIO exports and the physical LED pins.

Parameters:
- LED_W, 10: LED bank width.
- N_REQ, 4: number of requesters; requester 0 has top priority after reset.
- MAX_HOLD, 4096: quantum in clk_clk cycles; an owner is preempted after MAX_HOLD cycles only if another request is pending.
- GUARD_CYCLES, 16: blank interval on handoff (used only with LED_GUARD_EN).

Ports:
- clk_clk, in, 1: sole clock.
- reset_reset_n, in, 1: asynchronous, active-low reset.
- req_i, in, N_REQ: request per requester; held high while ownership is wanted, dropped to release.
- data_i, in, N_REQ*LED_W: requester k pattern at bits [k*LED_W +: LED_W].
- grant_o, out, N_REQ: one-hot current owner, or all zero.
- owner_valid_o, out, 1: high while any grant is active.
- owner_o, out, $clog2(N_REQ): index of the current owner; holds the last owner while idle.
- led_o, out, LED_W: registered LED drive.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is asynchronous and active-low, reset_reset_n.
- Reset values (applied immediately on reset assertion, including mid-tenure):
  - grant_o=0, owner_valid_o=0, owner_o=0, led_o=0.
  - rr_ptr=0, hold_cnt=0, state=IDLE.
- Arbitration function: winner = first asserted req_i bit scanning from ptr upward, modulo N_REQ.
- States: IDLE, OWN, plus GUARD when the macro is enabled.
- IDLE:
  - If req_i != 0 in cycle N, winner is computed with ptr=rr_ptr.
  - In cycle N+1: grant_o = onehot(winner), owner_o = winner, owner_valid_o=1, hold_cnt=0, state=OWN.
- OWN:
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Release condition A: the owner's req_i bit is 0 (voluntary).
  - Release condition B: hold_cnt == MAX_HOLD-1 and any other req_i bit is set (preemption). Tenure under contention is therefore exactly MAX_HOLD cycles.
  - Lone owner: never preempted; keeps the grant indefinitely while requesting.
  - On release in cycle N: rr_ptr = (owner+1) mod N_REQ, and the winner is computed from req_i in cycle N with ptr = owner+1.
    - If a winner exists: cycle N+1 grants it directly (back-to-back handoff, no idle cycle), hold_cnt=0.
    - If no winner: cycle N+1 gives grant_o=0, owner_valid_o=0, state=IDLE.
  - If A and B occur in the same cycle, the release is treated as voluntary; the result is identical.
  - A request newly asserted in the release cycle is eligible.
- LED path:
  - led_o(t+1) = data_i slice selected by grant_o(t) when owner_valid_o(t)=1, else 0.
  - Pattern latency is 2 cycles from request to LED: grant at N+1, led_o at N+2.
  - Data changes by the owner propagate with 1-cycle latency.
- Invariants:
  - grant_o is always one-hot or zero.
  - No requester is granted while its req_i is 0 at the decision cycle.
  - Round-robin fairness: under continuous contention every requester is granted within (N_REQ-1)*MAX_HOLD+1 cycles.

Optional Feature:
- Macro: LED_GUARD_EN.
- Enabled:
  - Every release enters GUARD for exactly GUARD_CYCLES cycles: grant_o=0, owner_valid_o=0, led_o=0.
  - At GUARD exit, arbitration runs on the current req_i with ptr = saved owner+1.
  - Requests dropped during GUARD are not granted.
  - A release with no pending requests still passes through GUARD, then goes to IDLE.
- Disabled: direct handoff as described above; the GUARD state and its counter are not compiled.

Test Plan:
- Reset: hold reset_reset_n=0 with random req_i/data_i -> all outputs 0. Release reset with req_i=0 -> outputs stay 0.
- Single owner: req_i=0001, data0=0x2AA at cycle N -> grant_o=0001 and owner_valid_o=1 at N+1, led_o=0x2AA at N+2. Drop req at M -> grant_o=0 at M+1, led_o=0 at M+2.
- Round robin: MAX_HOLD=8, req_i=1111 held -> grant sequence 0001,0010,0100,1000,0001, each exactly 8 cycles, no gaps. led_o tracks each owner's data 1 cycle behind.
- Lone requester: req_i=0100 held for 3*MAX_HOLD -> grant stays 0100 and hold_cnt saturates. Assert req_i[0] -> preemption to 0001 within 1 cycle of the (already expired) quantum check.
- Simultaneous events: owner drops req in the same cycle as quantum expiry while req_i[3]=1 -> next cycle grant_o=1000. Async reset pulsed mid-tenure -> outputs 0 immediately, then rr_ptr=0 arbitration.
- LED_GUARD_EN, GUARD_CYCLES=16: handoff 0001->0010 -> exactly 16 cycles of grant_o=0 and led_o=0, then grant_o=0010. Requester 1 dropping during guard -> IDLE, no grant.
